// File: rtl/fifo_ring_buffer_if.sv
// Handshake and status bundle between the ring-buffer FIFO and the UART/host logic.
interface fifo_ring_buffer_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  localparam int LW = $clog2(DEPTH + 1);

  logic              flush;
  logic              clr_err;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [LW-1:0]     level;
  logic              overflow;
  logic              underflow;

  modport master (
    output flush, clr_err, wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           level, overflow, underflow
  );

  modport slave (
    input  flush, clr_err, wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           level, overflow, underflow
  );
endinterface

// File: rtl/fifo_ring_buffer.sv
// Single-clock circular-buffer FIFO with wrap-around pointers, threshold flags,
// sticky error flags and synchronous flush.
module fifo_ring_buffer #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input logic               slow_clk,
  input logic               nreset,
  fifo_ring_buffer_if.slave bus
);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [LW-1:0]     level;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              overflow;
  logic              underflow;
  logic              empty;
  logic              full;
  logic              rd_ok;
  logic              wr_ok;

  // Explicit wrap so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty = (level == '0);
  assign full  = (level == LW'(DEPTH));

  // A full FIFO still accepts a write when a read frees a slot in the same cycle.
  assign rd_ok = bus.rd_en & ~empty;
  assign wr_ok = bus.wr_en & (~full | rd_ok);

  always_ff @(posedge slow_clk) begin
    if (wr_ok && !bus.flush) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge slow_clk or posedge nreset) begin
    if (nreset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      rd_valid <= rd_ok;
      if (rd_ok) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= ptr_inc(rd_ptr);
      end
      if (wr_ok) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      level     <= level + LW'(wr_ok) - LW'(rd_ok);
      // A new error event in the same cycle as clr_err keeps the flag set.
      overflow  <= (overflow  & ~bus.clr_err) | (bus.wr_en & ~wr_ok);
      underflow <= (underflow & ~bus.clr_err) | (bus.rd_en & ~rd_ok);
    end
  end

  assign bus.rd_data      = rd_data;
  assign bus.rd_valid     = rd_valid;
  assign bus.level        = level;
  assign bus.empty        = empty;
  assign bus.full         = full;
  assign bus.almost_full  = (level >= LW'(AF_LEVEL));
  assign bus.almost_empty = (level <= LW'(AE_LEVEL));
  assign bus.overflow     = overflow;
  assign bus.underflow    = underflow;
endmodule

// File: tb/tb_fifo_ring_buffer.sv
// Scoreboard bench for fifo_ring_buffer: a queue model predicts contents, pops and flags.
module tb_fifo_ring_buffer;
  localparam int DATA_W   = 8;
  localparam int DEPTH    = 16;
  localparam int AF_LEVEL = 14;
  localparam int AE_LEVEL = 2;

  logic slow_clk = 1'b0;
  logic nreset   = 1'b1;
  always #5 slow_clk = ~slow_clk;

  fifo_ring_buffer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  fifo_ring_buffer #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL), .AE_LEVEL(AE_LEVEL)
  ) dut (
    .slow_clk(slow_clk),
    .nreset  (nreset),
    .bus     (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [DATA_W-1:0] model_q[$];
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] last_rd = '0;
  logic              m_ovf   = 1'b0;
  logic              m_unf   = 1'b0;
  logic              exp_rv  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic check_status();
    int sz;
    sz = model_q.size();
    chk("level",        32'(bus.level),        32'(sz));
    chk("empty",        32'(bus.empty),        32'(sz == 0));
    chk("full",         32'(bus.full),         32'(sz == DEPTH));
    chk("almost_full",  32'(bus.almost_full),  32'(sz >= AF_LEVEL));
    chk("almost_empty", 32'(bus.almost_empty), 32'(sz <= AE_LEVEL));
    chk("overflow",     32'(bus.overflow),     32'(m_ovf));
    chk("underflow",    32'(bus.underflow),    32'(m_unf));
  endtask

  // One clock: predict, drive, clock, then compare what the DUT produced.
  task automatic step(input logic w, input logic [DATA_W-1:0] wd, input logic r,
                      input logic fl = 1'b0, input logic ce = 1'b0);
    logic rok, wok;
    exp_rv = 1'b0;
    if (fl) begin
      model_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      rok = r && (model_q.size() > 0);
      wok = w && ((model_q.size() < DEPTH) || rok);
      if (rok) begin
        exp_q.push_back(model_q.pop_front());
        exp_rv = 1'b1;
      end
      if (wok) model_q.push_back(wd);
      m_ovf = (m_ovf & ~ce) | (w & ~wok);
      m_unf = (m_unf & ~ce) | (r & ~rok);
    end
    bus.wr_en   = w;
    bus.wr_data = wd;
    bus.rd_en   = r;
    bus.flush   = fl;
    bus.clr_err = ce;
    @(posedge slow_clk);
    #1;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.flush   = 1'b0;
    bus.clr_err = 1'b0;
    chk("rd_valid", 32'(bus.rd_valid), 32'(exp_rv));
    if (bus.rd_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop", 32'(bus.rd_data), 32'hFFFF_FFFF);
      end else begin
        last_rd = exp_q.pop_front();
        chk("rd_data", 32'(bus.rd_data), 32'(last_rd));
      end
    end else begin
      exp_q.delete();
      chk("rd_data_hold", 32'(bus.rd_data), 32'(last_rd));
    end
    check_status();
  endtask

  initial begin
    bus.flush   = 1'b0;
    bus.clr_err = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.rd_en   = 1'b0;

    repeat (3) @(posedge slow_clk);
    #1;
    check_status();
    chk("rst_rd_data",  32'(bus.rd_data),  32'h0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 32'h0);
    nreset = 1'b0;
    @(posedge slow_clk);
    #1;

    // Fill to full, then one rejected write
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h11 + i), 1'b0);
    step(1'b1, 8'h55, 1'b0);

    // Drain in order, then one rejected read
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    chk("rd_data_after_drain", 32'(bus.rd_data), 32'h20);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Pointer wrap
    for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b1, 8'(8'h60 + i), 1'b0);
    for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1);

    // Full with simultaneous read and write
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h80 + i), 1'b0);
    step(1'b1, 8'hAA, 1'b1);
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1);

    // Empty with simultaneous read and write, then clr_err priority
    step(1'b1, 8'h77, 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Mixed concurrent traffic
    for (int i = 0; i < 40; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));

    // Flush with a concurrent write
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
    step(1'b1, 8'hEE, 1'b1, 1'b1);

    // Async reset mid-burst, checked before the next clock edge
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hD0 + i), 1'b0);
    step(1'b0, '0, 1'b1);
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'h99;
    #2;
    nreset = 1'b1;
    #1;
    model_q.delete();
    exp_q.delete();
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    last_rd = '0;
    check_status();
    chk("arst_rd_data",  32'(bus.rd_data),  32'h0);
    chk("arst_rd_valid", 32'(bus.rd_valid), 32'h0);
    bus.wr_en = 1'b0;
    @(posedge slow_clk);
    #1;
    nreset = 1'b0;
    step(1'b1, 8'h3C, 1'b0);
    step(1'b0, '0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
